// File: rtl/gc_dram_ctrl.sv
// Gain-cell DRAM controller: single-word client port plus an age-tracked read/write-back refresh engine.
// Reads respond 1 cycle after accept. req_ready drops while a refresh read or write-back uses the macro.
module gc_dram_ctrl #(
    parameter int ROWS        = 128,
    parameter int AW          = 7,
    parameter int DW          = 64,
    parameter int RETENTION   = 49,
    parameter int REFRESH_AGE = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          loss_valid,
    output logic [AW-1:0] loss_addr,
    output logic          dram_re,
    output logic          dram_we,
    output logic [AW-1:0] dram_raddr,
    output logic [AW-1:0] dram_waddr,
    output logic [DW-1:0] dram_in,
    input  logic [DW-1:0] dram_rd
);

    localparam int AGEW = $clog2(RETENTION + 1);
    localparam logic [AGEW-1:0] AGE_REF = AGEW'(REFRESH_AGE);
    localparam logic [AGEW-1:0] AGE_HI  = AGEW'(RETENTION - 2);
    localparam logic [AGEW-1:0] AGE_EXP = AGEW'(RETENTION - 1);
    localparam logic [AGEW-1:0] AGE_SAT = AGEW'(RETENTION);

    logic [ROWS-1:0] valid_q, valid_d;
    logic [AGEW-1:0] age_q [ROWS];
    logic [AGEW-1:0] age_d [ROWS];
    logic            wb_pend_q, wb_pend_d;
    logic [AW-1:0]   wb_row_q, wb_row_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic            loss_valid_q, loss_valid_d;
    logic [AW-1:0]   loss_addr_q, loss_addr_d;

    logic            ref_hit;
    logic [AW-1:0]   ref_row;
    logic            cmd_re, cmd_we;
    logic [AW-1:0]   cmd_raddr, cmd_waddr;
    logic [DW-1:0]   cmd_in;

    // Descending scan so the lowest eligible row wins.
    always_comb begin
        ref_hit = 1'b0;
        ref_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (valid_q[i] && age_q[i] >= AGE_REF && age_q[i] <= AGE_HI) begin
                ref_hit = 1'b1;
                ref_row = AW'(i);
            end
        end
    end

    assign req_ready = rst_n & ~wb_pend_q & ~ref_hit;

    always_comb begin
        cmd_re      = 1'b0;
        cmd_we      = 1'b0;
        cmd_raddr   = '0;
        cmd_waddr   = '0;
        cmd_in      = '0;
        wb_pend_d   = 1'b0;
        wb_row_d    = wb_row_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        if (rst_n) begin
            if (wb_pend_q) begin
                cmd_we    = 1'b1;
                cmd_waddr = wb_row_q;
                cmd_in    = dram_rd;
            end else if (ref_hit) begin
                cmd_re    = 1'b1;
                cmd_raddr = ref_row;
                wb_pend_d = 1'b1;
                wb_row_d  = ref_row;
            end else if (req_valid) begin
                if (req_we) begin
                    cmd_we    = 1'b1;
                    cmd_waddr = req_addr;
                    cmd_in    = req_wdata;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~valid_q[req_addr];
                    cmd_re      = valid_q[req_addr];
                    cmd_raddr   = valid_q[req_addr] ? req_addr : '0;
                end
            end
        end
    end

    // A write this cycle rescues a row that would otherwise expire at this edge.
    always_comb begin
        valid_d      = valid_q;
        loss_valid_d = 1'b0;
        loss_addr_d  = loss_addr_q;
        for (int i = ROWS - 1; i >= 0; i--) begin
            age_d[i] = age_q[i];
            if (cmd_we && cmd_waddr == AW'(i)) begin
                age_d[i]   = '0;
                valid_d[i] = 1'b1;
            end else if (valid_q[i] && age_q[i] == AGE_EXP) begin
                valid_d[i]   = 1'b0;
                loss_valid_d = 1'b1;
                loss_addr_d  = AW'(i);
            end else if (valid_q[i] && age_q[i] != AGE_SAT) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            wb_pend_q    <= 1'b0;
            wb_row_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            loss_valid_q <= 1'b0;
            loss_addr_q  <= '0;
            for (int i = 0; i < ROWS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            wb_pend_q    <= wb_pend_d;
            wb_row_q     <= wb_row_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            loss_valid_q <= loss_valid_d;
            loss_addr_q  <= loss_addr_d;
            for (int i = 0; i < ROWS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Registered outputs are also gated so they read 0 from the first reset cycle.
    assign rsp_valid  = rsp_valid_q & rst_n;
    assign rsp_err    = rsp_err_q & rst_n;
    assign rsp_data   = (rsp_valid_q && !rsp_err_q && rst_n) ? dram_rd : '0;
    assign loss_valid = loss_valid_q & rst_n;
    assign loss_addr  = rst_n ? loss_addr_q : '0;
    assign dram_re    = cmd_re;
    assign dram_we    = cmd_we;
    assign dram_raddr = cmd_raddr;
    assign dram_waddr = cmd_waddr;
    assign dram_in    = cmd_in;

endmodule

// File: tb/tb_gc_dram_ctrl.sv
// Bench for gc_dram_ctrl: timestamp-based reference model with directed and random client traffic.
module tb_gc_dram_ctrl;
    localparam int ROWS = 128, AW = 7, DW = 64, RET = 49, REF = 32, REF2 = 47;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          req_valid, req_ready, req_we, rsp_valid, rsp_err, loss_valid;
    logic [AW-1:0] req_addr, loss_addr, dram_raddr, dram_waddr;
    logic [DW-1:0] req_wdata, rsp_data, dram_in, dram_rd;
    logic          dram_re, dram_we;

    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err, b_loss_valid;
    logic [AW-1:0] b_req_addr, b_loss_addr, b_dram_raddr, b_dram_waddr;
    logic [DW-1:0] b_req_wdata, b_rsp_data, b_dram_in, b_dram_rd;
    logic          b_dram_re, b_dram_we;

    gc_dram_ctrl #(.ROWS(ROWS), .AW(AW), .DW(DW), .RETENTION(RET), .REFRESH_AGE(REF)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .loss_valid(loss_valid), .loss_addr(loss_addr), .dram_re(dram_re),
        .dram_we(dram_we), .dram_raddr(dram_raddr), .dram_waddr(dram_waddr), .dram_in(dram_in),
        .dram_rd(dram_rd));

    gc_dram_ctrl #(.ROWS(ROWS), .AW(AW), .DW(DW), .RETENTION(RET), .REFRESH_AGE(REF2)) dut47 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err), .loss_valid(b_loss_valid), .loss_addr(b_loss_addr), .dram_re(b_dram_re),
        .dram_we(b_dram_we), .dram_raddr(b_dram_raddr), .dram_waddr(b_dram_waddr), .dram_in(b_dram_in),
        .dram_rd(b_dram_rd));

    // Macro models: data read more than RET cycles after its last write comes back corrupted.
    int tcyc = 0;
    logic [DW-1:0] mem_a [ROWS];
    logic [DW-1:0] mem_b [ROWS];
    int mwt_a [ROWS];
    int mwt_b [ROWS];
    always @(posedge clk) begin
        tcyc <= tcyc + 1;
        if (dram_we) begin
            mem_a[dram_waddr] <= dram_in;
            mwt_a[dram_waddr] <= tcyc;
        end
        if (dram_re && !dram_we)
            dram_rd <= (tcyc - mwt_a[dram_raddr] <= RET) ? mem_a[dram_raddr] : 64'hBAD0_BAD0_BAD0_BAD0;
        if (b_dram_we) begin
            mem_b[b_dram_waddr] <= b_dram_in;
            mwt_b[b_dram_waddr] <= tcyc;
        end
        if (b_dram_re && !b_dram_we)
            b_dram_rd <= (tcyc - mwt_b[b_dram_raddr] <= RET) ? mem_b[b_dram_raddr] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: per row, cycle of last DRAM write, valid flag and data.
    int n = 0;
    int wt [ROWS];
    bit mv [ROWS];
    logic [DW-1:0] md [ROWS];
    bit wbp = 0;
    int wbrow = 0;
    bit e_rv = 0, e_re = 0, e_lv = 0;
    logic [DW-1:0] e_rd = '0;
    int e_la = 0;

    logic          sa_re, sa_we, sa_ready, sa_rv, sa_err, sa_lv;
    logic [AW-1:0] sa_raddr, sa_waddr;
    logic [DW-1:0] sa_rdata;
    logic          sb_re, sb_we, sb_ready, sb_rv, sb_err, sb_lv;
    logic [AW-1:0] sb_raddr, sb_waddr, sb_la;
    logic [DW-1:0] sb_in, sb_rdata;

    task automatic cyc();
        bit nrv, nre, nlv, cre, cwe, rdy;
        logic [DW-1:0] nrd, cin;
        int nla, ra, wa, wr, due;
        @(negedge clk);
        sa_re = dram_re; sa_we = dram_we; sa_ready = req_ready; sa_rv = rsp_valid;
        sa_err = rsp_err; sa_lv = loss_valid; sa_raddr = dram_raddr; sa_waddr = dram_waddr; sa_rdata = rsp_data;
        sb_re = b_dram_re; sb_we = b_dram_we; sb_ready = b_req_ready; sb_rv = b_rsp_valid; sb_err = b_rsp_err;
        sb_lv = b_loss_valid; sb_la = b_loss_addr; sb_raddr = b_dram_raddr; sb_waddr = b_dram_waddr;
        sb_in = b_dram_in; sb_rdata = b_rsp_data;
        chk("re_we_exclusive", 64'(dram_re & dram_we), 64'd0);
        if (!rst_n) begin
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_cmd", 64'({dram_re, dram_we, dram_raddr, dram_waddr}), 64'd0);
            chk("rst_din", dram_in, 64'd0);
            chk("rst_rsp", 64'({rsp_valid, rsp_err, loss_valid, loss_addr}), 64'd0);
            chk("rst_rdata", rsp_data, 64'd0);
            for (int r = 0; r < ROWS; r++) mv[r] = 0;
            wbp = 0; e_rv = 0; e_lv = 0;
        end else begin
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            if (e_rv) begin
                chk("rsp_err", 64'(rsp_err), 64'(e_re));
                chk("rsp_data", rsp_data, e_rd);
            end
            chk("loss_valid", 64'(loss_valid), 64'(e_lv));
            if (e_lv) chk("loss_addr", 64'(loss_addr), 64'(e_la));
            nrv = 0; nre = 0; nrd = '0; nlv = 0; nla = 0; cre = 0; cwe = 0;
            ra = 0; wa = 0; cin = '0; wr = -1; rdy = 0; due = -1;
            for (int r = ROWS - 1; r >= 0; r--)
                if (mv[r] && n - wt[r] - 1 >= REF && n - wt[r] - 1 <= RET - 2) due = r;
            if (wbp) begin
                cwe = 1; wa = wbrow; cin = md[wbrow]; wt[wbrow] = n; wr = wbrow; wbp = 0;
            end else if (due >= 0) begin
                cre = 1; ra = due; wbp = 1; wbrow = due;
            end else begin
                rdy = 1;
                if (req_valid && req_we) begin
                    cwe = 1; wa = int'(req_addr); cin = req_wdata; wr = wa;
                    wt[wa] = n; mv[wa] = 1; md[wa] = req_wdata;
                end else if (req_valid) begin
                    nrv = 1; nre = !mv[req_addr];
                    nrd = mv[req_addr] ? md[req_addr] : '0;
                    cre = mv[req_addr]; ra = int'(req_addr);
                end
            end
            chk("req_ready", 64'(req_ready), 64'(rdy));
            chk("dram_re", 64'(dram_re), 64'(cre));
            chk("dram_we", 64'(dram_we), 64'(cwe));
            if (cre) chk("dram_raddr", 64'(dram_raddr), 64'(ra));
            if (cwe) chk("dram_waddr", 64'(dram_waddr), 64'(wa));
            if (cwe) chk("dram_in", dram_in, cin);
            for (int r = 0; r < ROWS; r++)
                if (r != wr && mv[r] && n - wt[r] - 1 == RET - 1) begin
                    mv[r] = 0;
                    if (!nlv) begin nlv = 1; nla = r; end
                end
            e_rv = nrv; e_re = nre; e_rd = nrd; e_lv = nlv; e_la = nla;
        end
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input bit we, input int addr, input logic [DW-1:0] d);
        bit acc;
        acc = 0;
        req_valid = 1; req_we = we; req_addr = AW'(addr); req_wdata = d;
        for (int k = 0; k < 4 && !acc; k++) begin
            cyc();
            acc = sa_ready;
        end
        req_valid = 0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    int w3, last3, nloss, wn, c;
    logic [DW-1:0] da, db;

    initial begin
        rst_n = 0;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) cyc();
        rst_n = 1;
        cyc();
        chk("first_ready", 64'(sa_ready), 64'd1);
        chk("first_nocmd", 64'(sa_re | sa_we), 64'd0);

        a_req(1, 5, 64'hDEADBEEF01234567);
        chk("wr5_we", 64'({sa_we, sa_waddr}), 64'({1'b1, 7'd5}));
        a_req(0, 5, '0);
        chk("rd5_re", 64'({sa_re, sa_raddr}), 64'({1'b1, 7'd5}));
        cyc();
        chk("rd5_rsp", 64'({sa_rv, sa_err}), 64'd2);
        chk("rd5_data", sa_rdata, 64'hDEADBEEF01234567);

        a_req(0, 9, '0);
        chk("rd9_nocmd", 64'(sa_re), 64'd0);
        cyc();
        chk("rd9_rsp", 64'({sa_rv, sa_err}), 64'd3);
        chk("rd9_data", sa_rdata, 64'd0);

        a_req(1, 3, 64'h1);
        w3 = n - 1; last3 = -1; nloss = 0;
        while (n < w3 + 300) begin
            cyc();
            if (sa_lv) nloss++;
            if (sa_re && sa_raddr == 7'd3 && !sa_ready) begin
                if (last3 >= 0) chk("ref3_period", 64'(n - 1 - last3), 64'd34);
                else chk("ref3_first", 64'(n - 1 - w3), 64'd33);
                last3 = n - 1;
            end
        end
        chk("ref3_seen", 64'(last3 > w3), 64'd1);
        a_req(0, 3, '0);
        cyc();
        chk("rd3_data", sa_rdata, 64'h1);
        chk("rd3_noloss", 64'(nloss), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            req_valid = (i % 500 < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
            req_we = $urandom_range(0, 1) == 1;
            req_addr = AW'($urandom_range(0, 15));
            req_wdata = {$urandom, $urandom};
            cyc();
        end
        req_valid = 0;

        rst_n = 0;
        cyc();
        rst_n = 1;
        a_req(1, 3, 64'h33);
        repeat (32) cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        chk("no_wb_after_rst", 64'({sa_re, sa_we}), 64'd0);
        a_req(0, 3, '0);
        cyc();
        chk("rd3_after_rst", 64'({sa_rv, sa_err}), 64'd3);

        da = 64'hA5A5_0000_1111_2222;
        db = 64'h5A5A_3333_4444_5555;
        b_req_valid = 1; b_req_we = 1; b_req_addr = 7'd0; b_req_wdata = da;
        cyc();
        wn = n - 1;
        b_req_addr = 7'd1; b_req_wdata = db;
        cyc();
        b_req_valid = 0;
        while (n <= wn + 51) begin
            cyc();
            c = n - 1;
            if (c <= wn + 50) chk("b_noloss", 64'(sb_lv), 64'd0);
            if (c == wn + 48) begin
                chk("b_ref0_re", 64'({sb_re, sb_raddr}), 64'({1'b1, 7'd0}));
                chk("b_ref0_ready", 64'(sb_ready), 64'd0);
            end
            if (c == wn + 49) begin
                chk("b_wb0_we", 64'({sb_we, sb_waddr}), 64'({1'b1, 7'd0}));
                chk("b_wb0_in", sb_in, da);
            end
            if (c == wn + 50) begin
                chk("b_row1_noref", 64'({sb_re, sb_we}), 64'd0);
                chk("b_ready_back", 64'(sb_ready), 64'd1);
            end
            if (c == wn + 51) chk("b_loss", 64'({sb_lv, sb_la}), 64'({1'b1, 7'd1}));
        end
        b_req_valid = 1; b_req_we = 0; b_req_addr = 7'd1;
        cyc();
        b_req_addr = 7'd0;
        cyc();
        chk("b_rd1_err", 64'({sb_rv, sb_err}), 64'd3);
        chk("b_rd1_data", sb_rdata, 64'd0);
        b_req_valid = 0;
        cyc();
        chk("b_rd0_ok", 64'({sb_rv, sb_err}), 64'd2);
        chk("b_rd0_data", sb_rdata, da);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
